// File: rtl/bsram_arb_pkg.sv
// Shared types and sizes for the BSRAM save-file arbiter.
// Optional mapper dirty tracking is enabled with BSRAM_DIRTY_EN.
package bsram_arb_pkg;

    localparam int ADDR_W       = 20;
    localparam int DATA_W       = 8;
    localparam int HOST_LAT_DEF = 2;
    localparam int CNT_W        = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [DATA_W-1:0] wdata;
    } host_cmd_t;

endpackage

// File: rtl/bsram_dirty_track.sv
// Mapper write-edge detector with a sticky dirty flag.
// Built only when BSRAM_DIRTY_EN is defined.
module bsram_dirty_track
    import bsram_arb_pkg::*;
(
    input  logic mclk,
    input  logic rst_n,
    input  logic map_ce_n,
    input  logic map_we_n,
    input  logic dirty_clr,
    output logic dirty
);

    logic wr_n;
    logic wr_n_q;
    logic wr_fall;

    assign wr_n    = map_ce_n | map_we_n;
    assign wr_fall = wr_n_q & ~wr_n;

    // A new write edge wins over a simultaneous clear.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_n_q <= 1'b1;
            dirty  <= 1'b0;
        end else begin
            wr_n_q <= wr_n;
            if (wr_fall) begin
                dirty <= 1'b1;
            end else if (dirty_clr) begin
                dirty <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/bsram_save_arbiter.sv
// BSRAM arbiter: mapper has absolute priority, host save access is retried on preemption.
// Define BSRAM_DIRTY_EN to build the mapper dirty tracker.
module bsram_save_arbiter
    import bsram_arb_pkg::*;
#(
    parameter int HOST_LAT = HOST_LAT_DEF
)
(
    input  logic              mclk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] map_addr,
    input  logic [DATA_W-1:0] map_d,
    input  logic              map_ce_n,
    input  logic              map_oe_n,
    input  logic              map_we_n,
    output logic [DATA_W-1:0] map_q,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    input  logic [ADDR_W-1:0] bsram_mask,
    output logic [ADDR_W-1:0] bsram_addr,
    output logic [DATA_W-1:0] bsram_d,
    output logic              bsram_ce_n,
    output logic              bsram_oe_n,
    output logic              bsram_we_n,
    input  logic [DATA_W-1:0] bsram_q,
    input  logic              dirty_clr,
    output logic              dirty
);

    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(HOST_LAT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    host_cmd_t        cmd;
    logic             map_sel;
    logic             host_drive;

    assign map_sel    = ~map_ce_n;
    assign host_drive = (state == SETUP) || (state == ACCESS);
    assign map_q      = bsram_q;

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            cmd        <= '0;
            host_rdata <= '0;
            host_ack   <= 1'b0;
        end else begin
            host_ack <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (host_req) begin
                        cmd.addr  <= host_addr;
                        cmd.we    <= host_we;
                        cmd.wdata <= host_wdata;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    cnt <= LAT_LOAD;
                    if (!map_sel) begin
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Any mapper cycle aborts the attempt; it restarts from SETUP.
                    if (map_sel) begin
                        cnt   <= LAT_LOAD;
                        state <= SETUP;
                    end else if (cnt == '0) begin
                        if (!cmd.we) begin
                            host_rdata <= bsram_q;
                        end
                        host_ack <= 1'b1;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        bsram_addr = '0;
        bsram_d    = '0;
        bsram_ce_n = 1'b1;
        bsram_oe_n = 1'b1;
        bsram_we_n = 1'b1;
        if (map_sel) begin
            bsram_addr = map_addr;
            bsram_d    = map_d;
            bsram_ce_n = map_ce_n;
            bsram_oe_n = map_oe_n;
            bsram_we_n = map_we_n;
        end else if (host_drive) begin
            bsram_addr = cmd.addr & bsram_mask;
            bsram_d    = cmd.wdata;
            bsram_ce_n = 1'b0;
            bsram_oe_n = cmd.we;
            bsram_we_n = ~cmd.we;
        end
    end

`ifdef BSRAM_DIRTY_EN
    bsram_dirty_track u_dirty (
        .mclk      (mclk),
        .rst_n     (rst_n),
        .map_ce_n  (map_ce_n),
        .map_we_n  (map_we_n),
        .dirty_clr (dirty_clr),
        .dirty     (dirty)
    );
`else
    logic unused_dirty_clr;
    assign unused_dirty_clr = dirty_clr;
    assign dirty            = 1'b0;
`endif

endmodule
